// File: rtl/ibex_fetch_align_fifo_if.sv
// Handshake/bus bundle between the prefetch response path, the fetch align FIFO
// and the IF stage.
interface ibex_fetch_align_fifo_if #(
    parameter int unsigned NUM_REQS = 2
);
    logic                clear_i;
    logic [NUM_REQS-1:0] busy_o;
    logic                in_valid_i;
    logic [31:0]         in_addr_i;
    logic [31:0]         in_rdata_i;
    logic                in_err_i;
    logic                out_valid_o;
    logic                out_ready_i;
    logic [31:0]         out_rdata_o;
    logic [31:0]         out_addr_o;
    logic                out_err_o;
    logic                out_err_plus2_o;

    modport slave (
        input  clear_i, in_valid_i, in_addr_i, in_rdata_i, in_err_i, out_ready_i,
        output busy_o, out_valid_o, out_rdata_o, out_addr_o, out_err_o, out_err_plus2_o
    );

    modport master (
        output clear_i, in_valid_i, in_addr_i, in_rdata_i, in_err_i, out_ready_i,
        input  busy_o, out_valid_o, out_rdata_o, out_addr_o, out_err_o, out_err_plus2_o
    );
endinterface

// File: rtl/ibex_fetch_align_fifo.sv
// Fetch-word queue with zero-latency bypass that realigns compressed, aligned and
// straddling instructions for the IF stage and tracks the head PC.
module ibex_fetch_align_fifo #(
    parameter int unsigned NUM_REQS = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    ibex_fetch_align_fifo_if.slave bus
);
    localparam int unsigned DEPTH = NUM_REQS + 1;

    logic [31:0]      rdata_q [DEPTH];
    logic [DEPTH-1:0] err_q;
    logic [DEPTH-1:0] valid_q;
    logic [31:0]      pc_q;

    logic [31:0] word0;
    logic [15:0] word1_lo;
    logic        err0, err1, w0_vld, w1_vld;
    logic        aligned, compressed, out_valid, handshake, pop;

    logic [DEPTH:0]   vq_ext, below, ext_vld;
    logic [31:0]      ext_data [DEPTH+1];
    logic [DEPTH:0]   ext_err;
    logic [31:0]      data_d [DEPTH];
    logic [DEPTH-1:0] err_d, valid_d;

    // Empty slots are filled straight from the incoming word so the head can issue in the arrival cycle.
    assign word0    = valid_q[0] ? rdata_q[0] : bus.in_rdata_i;
    assign err0     = valid_q[0] ? err_q[0] : (bus.in_valid_i & bus.in_err_i);
    assign w0_vld   = valid_q[0] | bus.in_valid_i;
    assign word1_lo = valid_q[1] ? rdata_q[1][15:0] : bus.in_rdata_i[15:0];
    assign err1     = valid_q[1] ? err_q[1] : (valid_q[0] & bus.in_valid_i & bus.in_err_i);
    assign w1_vld   = valid_q[1] | (valid_q[0] & bus.in_valid_i);

    assign aligned    = ~pc_q[1];
    assign compressed = aligned ? (word0[1:0] != 2'b11) : (word0[17:16] != 2'b11);

    always_comb begin
        out_valid           = 1'b0;
        bus.out_rdata_o     = word0;
        bus.out_err_o       = err0;
        bus.out_err_plus2_o = 1'b0;
        if (aligned) begin
            out_valid = w0_vld;
        end else begin
            bus.out_rdata_o = {word1_lo, word0[31:16]};
            if (compressed) begin
                out_valid = w0_vld;
            end else begin
                // A faulting first half is reported without waiting for the second word.
                out_valid           = w1_vld | (w0_vld & err0);
                bus.out_err_o       = err0 | err1;
                bus.out_err_plus2_o = ~err0 & err1;
            end
        end
    end

    assign bus.out_valid_o = out_valid;
    assign bus.out_addr_o  = pc_q;
    assign bus.busy_o      = valid_q[DEPTH-1:DEPTH-NUM_REQS];

    assign handshake = out_valid & bus.out_ready_i;
    assign pop       = handshake & ~(aligned & compressed);

    // Stored entries plus the arriving word form a DEPTH+1 view; a pop then shifts it down by one.
    always_comb begin
        vq_ext  = {1'b0, valid_q};
        below   = {valid_q, 1'b1};
        ext_vld = vq_ext | ({(DEPTH+1){bus.in_valid_i}} & below & ~vq_ext);
        for (int k = 0; k < DEPTH; k++) begin
            ext_data[k] = valid_q[k] ? rdata_q[k] : bus.in_rdata_i;
            ext_err[k]  = valid_q[k] ? err_q[k] : bus.in_err_i;
        end
        ext_data[DEPTH] = bus.in_rdata_i;
        ext_err[DEPTH]  = bus.in_err_i;
        for (int k = 0; k < DEPTH; k++) begin
            data_d[k] = pop ? ext_data[k+1] : ext_data[k];
        end
        err_d   = pop ? ext_err[DEPTH:1] : ext_err[DEPTH-1:0];
        valid_d = pop ? ext_vld[DEPTH:1] : ext_vld[DEPTH-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            pc_q    <= '0;
        end else if (bus.clear_i) begin
            valid_q <= '0;
            pc_q    <= bus.in_addr_i & 32'hFFFF_FFFE;
        end else begin
            valid_q <= valid_d;
            if (handshake) begin
                pc_q <= pc_q + (compressed ? 32'd2 : 32'd4);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < DEPTH; k++) begin
            rdata_q[k] <= data_d[k];
        end
        err_q <= err_d;
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(bus.in_valid_i & (&valid_q) & ~pop & ~bus.clear_i));

endmodule

// File: tb/tb_ibex_fetch_align_fifo.sv
// Directed bench for ibex_fetch_align_fifo: bypass, alignment, errors, fill level,
// clear priority, PC wrap and asynchronous reset.
module tb_ibex_fetch_align_fifo;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    logic [15:0] lo;

    ibex_fetch_align_fifo_if #(.NUM_REQS(2)) bus ();

    ibex_fetch_align_fifo #(.NUM_REQS(2)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.clear_i     = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.in_addr_i   = 32'h0;
        bus.in_rdata_i  = 32'h0;
        bus.in_err_i    = 1'b0;
        bus.out_ready_i = 1'b0;
    endtask

    task automatic do_clear(input logic [31:0] addr);
        bus.clear_i    = 1'b1;
        bus.in_valid_i = 1'b0;
        bus.in_err_i   = 1'b0;
        bus.in_addr_i  = addr;
        tick();
        bus.clear_i    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        repeat (2) tick();
        n_vec++; if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", bus.out_valid_o); end
        n_vec++; if (bus.busy_o !== 2'b00) begin n_err++; $display("FAIL rst_busy got %b want 00", bus.busy_o); end
        n_vec++; if (bus.out_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_addr got %h want 0", bus.out_addr_o); end
        n_vec++; if (bus.out_err_o !== 1'b0) begin n_err++; $display("FAIL rst_err got %b want 0", bus.out_err_o); end
        n_vec++; if (bus.out_err_plus2_o !== 1'b0) begin n_err++; $display("FAIL rst_err_plus2 got %b want 0", bus.out_err_plus2_o); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_aligned();
        do_clear(32'h80);
        bus.in_valid_i  = 1'b1;
        bus.in_rdata_i  = 32'h00B5_0513;
        bus.out_ready_i = 1'b1;
        #1;
        n_vec++; if (bus.out_valid_o !== 1'b1) begin n_err++; $display("FAIL al_bypass_valid got %b want 1", bus.out_valid_o); end
        n_vec++; if (bus.out_rdata_o !== 32'h00B5_0513) begin n_err++; $display("FAIL al_rdata0 got %h want 00b50513", bus.out_rdata_o); end
        n_vec++; if (bus.out_addr_o !== 32'h80) begin n_err++; $display("FAIL al_addr0 got %h want 80", bus.out_addr_o); end
        n_vec++; if (bus.out_err_o !== 1'b0) begin n_err++; $display("FAIL al_err0 got %b want 0", bus.out_err_o); end
        tick();
        bus.in_rdata_i = 32'h00C5_8593;
        #1;
        n_vec++; if (bus.out_rdata_o !== 32'h00C5_8593) begin n_err++; $display("FAIL al_rdata1 got %h want 00c58593", bus.out_rdata_o); end
        n_vec++; if (bus.out_addr_o !== 32'h84) begin n_err++; $display("FAIL al_addr1 got %h want 84", bus.out_addr_o); end
        tick();
        bus.in_valid_i = 1'b0;
        #1;
        n_vec++; if (bus.out_addr_o !== 32'h88) begin n_err++; $display("FAIL al_addr2 got %h want 88", bus.out_addr_o); end
        n_vec++; if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL al_empty got %b want 0", bus.out_valid_o); end
        idle();
    endtask

    task automatic test_unaligned_compressed();
        do_clear(32'h102);
        bus.in_valid_i  = 1'b1;
        bus.in_rdata_i  = 32'h4505_0000;
        bus.out_ready_i = 1'b1;
        #1;
        lo = bus.out_rdata_o[15:0];
        n_vec++; if (bus.out_valid_o !== 1'b1) begin n_err++; $display("FAIL uc_valid got %b want 1", bus.out_valid_o); end
        n_vec++; if (lo !== 16'h4505) begin n_err++; $display("FAIL uc_rdata got %h want 4505", lo); end
        n_vec++; if (bus.out_addr_o !== 32'h102) begin n_err++; $display("FAIL uc_addr got %h want 102", bus.out_addr_o); end
        tick();
        bus.in_valid_i = 1'b0;
        #1;
        n_vec++; if (bus.out_addr_o !== 32'h104) begin n_err++; $display("FAIL uc_next_addr got %h want 104", bus.out_addr_o); end
        n_vec++; if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL uc_empty got %b want 0", bus.out_valid_o); end
        n_vec++; if (bus.busy_o !== 2'b00) begin n_err++; $display("FAIL uc_busy got %b want 00", bus.busy_o); end
        idle();
    endtask

    task automatic test_straddle();
        do_clear(32'h202);
        bus.in_valid_i  = 1'b1;
        bus.in_rdata_i  = 32'h0513_ABCD;
        bus.out_ready_i = 1'b1;
        #1;
        n_vec++; if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL st_wait got %b want 0", bus.out_valid_o); end
        tick();
        bus.in_rdata_i = 32'h1234_00B5;
        #1;
        n_vec++; if (bus.out_valid_o !== 1'b1) begin n_err++; $display("FAIL st_valid got %b want 1", bus.out_valid_o); end
        n_vec++; if (bus.out_rdata_o !== 32'h00B5_0513) begin n_err++; $display("FAIL st_rdata got %h want 00b50513", bus.out_rdata_o); end
        n_vec++; if (bus.out_addr_o !== 32'h202) begin n_err++; $display("FAIL st_addr got %h want 202", bus.out_addr_o); end
        n_vec++; if (bus.out_err_o !== 1'b0) begin n_err++; $display("FAIL st_err got %b want 0", bus.out_err_o); end
        tick();
        bus.in_valid_i = 1'b0;
        #1;
        n_vec++; if (bus.out_addr_o !== 32'h206) begin n_err++; $display("FAIL st_next_addr got %h want 206", bus.out_addr_o); end
        idle();
    endtask

    task automatic test_errors();
        do_clear(32'h202);
        bus.in_valid_i = 1'b1;
        bus.in_rdata_i = 32'h0513_ABCD;
        #1;
        n_vec++; if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL er_wait got %b want 0", bus.out_valid_o); end
        tick();
        bus.in_rdata_i = 32'h1234_00B5;
        bus.in_err_i   = 1'b1;
        #1;
        n_vec++; if (bus.out_valid_o !== 1'b1) begin n_err++; $display("FAIL er2_valid got %b want 1", bus.out_valid_o); end
        n_vec++; if (bus.out_err_o !== 1'b1) begin n_err++; $display("FAIL er2_err got %b want 1", bus.out_err_o); end
        n_vec++; if (bus.out_err_plus2_o !== 1'b1) begin n_err++; $display("FAIL er2_plus2 got %b want 1", bus.out_err_plus2_o); end
        tick();
        do_clear(32'h202);
        bus.in_valid_i = 1'b1;
        bus.in_rdata_i = 32'h0513_ABCD;
        bus.in_err_i   = 1'b1;
        #1;
        n_vec++; if (bus.out_valid_o !== 1'b1) begin n_err++; $display("FAIL er1_valid got %b want 1", bus.out_valid_o); end
        n_vec++; if (bus.out_err_o !== 1'b1) begin n_err++; $display("FAIL er1_err got %b want 1", bus.out_err_o); end
        n_vec++; if (bus.out_err_plus2_o !== 1'b0) begin n_err++; $display("FAIL er1_plus2 got %b want 0", bus.out_err_plus2_o); end
        idle();
        tick();
    endtask

    task automatic test_fill_clear();
        do_clear(32'h0);
        bus.in_valid_i = 1'b1;
        bus.in_rdata_i = 32'h0000_0013;
        tick();
        n_vec++; if (bus.busy_o !== 2'b00) begin n_err++; $display("FAIL fc_busy1 got %b want 00", bus.busy_o); end
        tick();
        n_vec++; if (bus.busy_o !== 2'b01) begin n_err++; $display("FAIL fc_busy2 got %b want 01", bus.busy_o); end
        tick();
        n_vec++; if (bus.busy_o !== 2'b11) begin n_err++; $display("FAIL fc_busy3 got %b want 11", bus.busy_o); end
        n_vec++; if (bus.out_valid_o !== 1'b1) begin n_err++; $display("FAIL fc_full_valid got %b want 1", bus.out_valid_o); end
        n_vec++; if (bus.out_addr_o !== 32'h0) begin n_err++; $display("FAIL fc_full_addr got %h want 0", bus.out_addr_o); end
        bus.clear_i   = 1'b1;
        bus.in_addr_i = 32'h300;
        tick();
        bus.clear_i    = 1'b0;
        bus.in_valid_i = 1'b0;
        #1;
        n_vec++; if (bus.busy_o !== 2'b00) begin n_err++; $display("FAIL fc_clr_busy got %b want 00", bus.busy_o); end
        n_vec++; if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL fc_clr_valid got %b want 0", bus.out_valid_o); end
        n_vec++; if (bus.out_addr_o !== 32'h300) begin n_err++; $display("FAIL fc_clr_addr got %h want 300", bus.out_addr_o); end
        idle();
    endtask

    task automatic test_wrap_and_odd();
        do_clear(32'hFFFF_FFFC);
        bus.in_valid_i  = 1'b1;
        bus.in_rdata_i  = 32'h0000_0013;
        bus.out_ready_i = 1'b1;
        #1;
        n_vec++; if (bus.out_addr_o !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wr_addr got %h want fffffffc", bus.out_addr_o); end
        n_vec++; if (bus.out_valid_o !== 1'b1) begin n_err++; $display("FAIL wr_valid got %b want 1", bus.out_valid_o); end
        tick();
        bus.in_valid_i = 1'b0;
        #1;
        n_vec++; if (bus.out_addr_o !== 32'h0) begin n_err++; $display("FAIL wr_wrap got %h want 0", bus.out_addr_o); end
        idle();
        do_clear(32'h401);
        n_vec++; if (bus.out_addr_o !== 32'h400) begin n_err++; $display("FAIL odd_addr got %h want 400", bus.out_addr_o); end
    endtask

    task automatic test_async_reset();
        do_clear(32'h500);
        bus.in_valid_i = 1'b1;
        bus.in_rdata_i = 32'h0000_0013;
        repeat (2) tick();
        bus.in_valid_i = 1'b0;
        #1;
        n_vec++; if (bus.busy_o !== 2'b01) begin n_err++; $display("FAIL ar_pre_busy got %b want 01", bus.busy_o); end
        #1;
        rst_n = 1'b0;
        #1;
        n_vec++; if (bus.busy_o !== 2'b00) begin n_err++; $display("FAIL ar_busy got %b want 00", bus.busy_o); end
        n_vec++; if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL ar_valid got %b want 0", bus.out_valid_o); end
        n_vec++; if (bus.out_addr_o !== 32'h0) begin n_err++; $display("FAIL ar_addr got %h want 0", bus.out_addr_o); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_aligned();
        test_unaligned_compressed();
        test_straddle();
        test_errors();
        test_fill_clear();
        test_wrap_and_odd();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
